// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and monitor states for the traffic phase monitor.
package traffic_pkg;

    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b1010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;

    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_OFF   = 2'b00;

    typedef enum logic [2:0] {
        FLT_NONE        = 3'd0,
        FLT_ILLEGAL     = 3'd1,
        FLT_CONFLICT    = 3'd2,
        FLT_TRANSITION  = 3'd3,
        FLT_YEL_TIMEOUT = 3'd4
    } fault_code_t;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

    function automatic logic car_legal(input logic [3:0] code);
        return (code == CAR_RED) || (code == CAR_YELLOW) ||
               (code == CAR_LEFT) || (code == CAR_GREEN);
    endfunction

    function automatic logic walk_legal(input logic [1:0] code);
        return code != 2'b11;
    endfunction

endpackage

// File: rtl/traffic_path_tracker.sv
// Per-path sample history, dwell counter, pedestrian countdown and per-path fault flags.
module traffic_path_tracker
    import traffic_pkg::*;
#(
    parameter int YEL_MAX        = 8,
    parameter int WALK_GREEN_LEN = 14,
    parameter int CNT_W          = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       car,
    input  logic [1:0]       walk,
    input  logic             gate_open,
    output logic [CNT_W-1:0] dwell,
    output logic [3:0]       walk_remain,
    output logic             code_bad,
    output logic             car_go,
    output logic             walk_go,
    output logic             trans_bad,
    output logic             yel_timeout
);

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] YEL_LIMIT = CNT_W'(YEL_MAX - 1);
    localparam logic [3:0]       WALK_LOAD = 4'(WALK_GREEN_LEN - 1);

    logic [3:0]       prev_car_reg;
    logic [1:0]       prev_walk_reg;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic [3:0]       walk_remain_reg, walk_remain_next;
    logic             move_ok;

    always_comb begin
        dwell_next = dwell_reg;
        if (car != prev_car_reg)
            dwell_next = '0;
        else if (dwell_reg != DWELL_MAX)
            dwell_next = dwell_reg + CNT_W'(1);
    end

    always_comb begin
        walk_remain_next = '0;
        if (walk == WALK_GREEN) begin
            if (prev_walk_reg != WALK_GREEN)
                walk_remain_next = WALK_LOAD;
            else if (walk_remain_reg != 4'd0)
                walk_remain_next = walk_remain_reg - 4'd1;
        end
    end

    // RED->YELLOW is only a legal shortcut under a VIP or night override.
    always_comb begin
        move_ok = 1'b0;
        case (prev_car_reg)
            CAR_GREEN, CAR_LEFT: move_ok = (car == CAR_YELLOW);
            CAR_RED:             move_ok = (car == CAR_GREEN) || ((car == CAR_YELLOW) && gate_open);
            CAR_YELLOW:          move_ok = car_legal(car);
            default:             move_ok = 1'b0;
        endcase
    end

    assign code_bad    = !car_legal(car) || !walk_legal(walk);
    assign car_go      = (car == CAR_GREEN) || (car == CAR_LEFT);
    assign walk_go     = (walk == WALK_GREEN);
    assign trans_bad   = (car != prev_car_reg) && !move_ok;
    // dwell_next counts the current sample, so this fires on the YEL_MAX-th yellow sample.
    assign yel_timeout = (car == CAR_YELLOW) && (dwell_next >= YEL_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_car_reg    <= CAR_RED;
            prev_walk_reg   <= WALK_RED;
            dwell_reg       <= '0;
            walk_remain_reg <= '0;
        end else begin
            prev_car_reg    <= car;
            prev_walk_reg   <= walk;
            dwell_reg       <= dwell_next;
            walk_remain_reg <= walk_remain_next;
        end
    end

    assign dwell       = dwell_reg;
    assign walk_remain = walk_remain_reg;

endmodule

// File: rtl/traffic_phase_monitor.sv
// Two-path light monitor: cross-path conflict check, fault priority and the IDLE/RUN/FAULT FSM.
module traffic_phase_monitor
    import traffic_pkg::*;
#(
    parameter int YEL_MAX        = 8,
    parameter int WALK_GREEN_LEN = 14,
    parameter int CNT_W          = 7
) (
    input  logic             clk,
    input  logic             start,
    input  logic [3:0]       car_a,
    input  logic [1:0]       walk_a,
    input  logic [3:0]       car_b,
    input  logic [1:0]       walk_b,
    input  logic             isvip,
    input  logic             isnight,
    input  logic             clear_fault,
    output logic             safe_mode,
    output logic [2:0]       fault_code,
    output logic             fault_path,
    output logic [CNT_W-1:0] dwell_a,
    output logic [CNT_W-1:0] dwell_b,
    output logic [3:0]       walk_remain_a,
    output logic [3:0]       walk_remain_b
);

    logic [3:0]       car_in [2];
    logic [1:0]       walk_in [2];
    logic [CNT_W-1:0] dwell_arr [2];
    logic [3:0]       walk_remain_arr [2];
    logic [1:0]       code_bad, car_go, walk_go, trans_bad, yel_timeout;
    logic             gate_open, conflict;

    mon_state_t  state_reg, state_next;
    fault_code_t fault_code_reg, fault_code_next, fault_sel;
    logic        fault_path_reg, fault_path_next, path_sel;

    assign car_in[0]  = car_a;
    assign car_in[1]  = car_b;
    assign walk_in[0] = walk_a;
    assign walk_in[1] = walk_b;
    assign gate_open  = isvip | isnight;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_path
            traffic_path_tracker #(
                .YEL_MAX        (YEL_MAX),
                .WALK_GREEN_LEN (WALK_GREEN_LEN),
                .CNT_W          (CNT_W)
            ) u_tracker (
                .clk         (clk),
                .rst_n       (start),
                .car         (car_in[gi]),
                .walk        (walk_in[gi]),
                .gate_open   (gate_open),
                .dwell       (dwell_arr[gi]),
                .walk_remain (walk_remain_arr[gi]),
                .code_bad    (code_bad[gi]),
                .car_go      (car_go[gi]),
                .walk_go     (walk_go[gi]),
                .trans_bad   (trans_bad[gi]),
                .yel_timeout (yel_timeout[gi])
            );
        end
    endgenerate

    assign conflict = (&car_go) || (|(car_go & walk_go));

    // Class priority conflict > illegal > transition > timeout; path A wins within a class.
    always_comb begin
        fault_sel = FLT_NONE;
        path_sel  = 1'b0;
        if (conflict) begin
            fault_sel = FLT_CONFLICT;
        end else if (|code_bad) begin
            fault_sel = FLT_ILLEGAL;
            path_sel  = !code_bad[0];
        end else if (|trans_bad) begin
            fault_sel = FLT_TRANSITION;
            path_sel  = !trans_bad[0];
        end else if (|yel_timeout) begin
            fault_sel = FLT_YEL_TIMEOUT;
            path_sel  = !yel_timeout[0];
        end
    end

    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        fault_path_next = fault_path_reg;
        case (state_reg)
            MON_IDLE: state_next = MON_RUN;
            MON_RUN: begin
                if (fault_sel != FLT_NONE) begin
                    state_next      = MON_FAULT;
                    fault_code_next = fault_sel;
                    fault_path_next = path_sel;
                end
            end
            MON_FAULT: begin
                if (clear_fault) begin
                    state_next      = MON_IDLE;
                    fault_code_next = FLT_NONE;
                    fault_path_next = 1'b0;
                end
            end
            default: state_next = MON_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_reg      <= MON_IDLE;
            fault_code_reg <= FLT_NONE;
            fault_path_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fault_code_reg <= fault_code_next;
            fault_path_reg <= fault_path_next;
        end
    end

    assign safe_mode     = (state_reg == MON_FAULT);
    assign fault_code    = fault_code_reg;
    assign fault_path    = fault_path_reg;
    assign dwell_a       = dwell_arr[0];
    assign dwell_b       = dwell_arr[1];
    assign walk_remain_a = walk_remain_arr[0];
    assign walk_remain_b = walk_remain_arr[1];

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Directed scenarios plus sticky-random light codes, checked every cycle against a sample-history model.
module tb_traffic_phase_monitor;

    localparam int YEL_MAX  = 8;
    localparam int WALK_LEN = 14;
    localparam int CNT_W    = 7;
    localparam int DW_SAT   = (1 << CNT_W) - 1;

    localparam logic [3:0] C_RED = 4'b1000, C_YEL = 4'b0100, C_LEFT = 4'b1010, C_GRN = 4'b0001;
    localparam logic [1:0] W_RED = 2'b10, W_GRN = 2'b01, W_OFF = 2'b00;

    localparam int S_IDLE = 0, S_RUN = 1, S_FAULT = 2;

    logic             clk = 1'b0;
    logic             start;
    logic [3:0]       car_a, car_b;
    logic [1:0]       walk_a, walk_b;
    logic             isvip, isnight, clear_fault;
    logic             safe_mode, fault_path;
    logic [2:0]       fault_code;
    logic [CNT_W-1:0] dwell_a, dwell_b;
    logic [3:0]       walk_remain_a, walk_remain_b;

    int vectors = 0;
    int miscompares = 0;

    // Model: last sample per path plus derived counters, and the monitor mode.
    logic [3:0] m_prev_car [2];
    logic [1:0] m_prev_walk [2];
    int m_dwell [2];
    int m_walk [2];
    int m_yel_run [2];
    int m_state, m_code, m_path;

    typedef struct {
        logic [3:0] from;
        logic [3:0] to;
        bit         gated;
    } move_t;

    move_t moves [7];

    traffic_phase_monitor #(
        .YEL_MAX        (YEL_MAX),
        .WALK_GREEN_LEN (WALK_LEN),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .start         (start),
        .car_a         (car_a),
        .walk_a        (walk_a),
        .car_b         (car_b),
        .walk_b        (walk_b),
        .isvip         (isvip),
        .isnight       (isnight),
        .clear_fault   (clear_fault),
        .safe_mode     (safe_mode),
        .fault_code    (fault_code),
        .fault_path    (fault_path),
        .dwell_a       (dwell_a),
        .dwell_b       (dwell_b),
        .walk_remain_a (walk_remain_a),
        .walk_remain_b (walk_remain_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit is_car(input logic [3:0] c);
        return c == C_RED || c == C_YEL || c == C_LEFT || c == C_GRN;
    endfunction

    function automatic bit move_allowed(input logic [3:0] from, input logic [3:0] to, input bit gate);
        for (int i = 0; i < 7; i++)
            if (moves[i].from == from && moves[i].to == to && (!moves[i].gated || gate))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_prev_car[p]  = C_RED;
            m_prev_walk[p] = W_RED;
            m_dwell[p]     = 0;
            m_walk[p]      = 0;
            m_yel_run[p]   = 0;
        end
        m_state = S_IDLE;
        m_code  = 0;
        m_path  = 0;
    endtask

    task automatic model_clock();
        logic [3:0] car [2];
        logic [1:0] wk [2];
        bit bad [2], go [2], wgo [2], trn [2], tmo [2];
        int code, path;
        car[0] = car_a; car[1] = car_b;
        wk[0]  = walk_a; wk[1] = walk_b;
        for (int p = 0; p < 2; p++) begin
            bad[p] = !is_car(car[p]) || wk[p] == 2'b11;
            go[p]  = car[p] == C_GRN || car[p] == C_LEFT;
            wgo[p] = wk[p] == W_GRN;
            trn[p] = car[p] != m_prev_car[p] && !move_allowed(m_prev_car[p], car[p], isvip || isnight);
            m_yel_run[p] = (car[p] != C_YEL) ? 0 : (m_prev_car[p] == C_YEL ? m_yel_run[p] + 1 : 1);
            tmo[p] = m_yel_run[p] >= YEL_MAX;
            m_dwell[p] = (car[p] != m_prev_car[p]) ? 0 : (m_dwell[p] < DW_SAT ? m_dwell[p] + 1 : DW_SAT);
            if (wk[p] != W_GRN)            m_walk[p] = 0;
            else if (m_prev_walk[p] != W_GRN) m_walk[p] = WALK_LEN - 1;
            else if (m_walk[p] > 0)        m_walk[p] = m_walk[p] - 1;
        end
        code = 0; path = 0;
        if ((go[0] && go[1]) || (go[0] && wgo[0]) || (go[1] && wgo[1])) code = 2;
        else if (bad[0] || bad[1]) begin code = 1; path = bad[0] ? 0 : 1; end
        else if (trn[0] || trn[1]) begin code = 3; path = trn[0] ? 0 : 1; end
        else if (tmo[0] || tmo[1]) begin code = 4; path = tmo[0] ? 0 : 1; end
        if (m_state == S_IDLE) m_state = S_RUN;
        else if (m_state == S_RUN) begin
            if (code != 0) begin m_state = S_FAULT; m_code = code; m_path = path; end
        end else if (clear_fault) begin
            m_state = S_IDLE; m_code = 0; m_path = 0;
        end
        for (int p = 0; p < 2; p++) begin
            m_prev_car[p]  = car[p];
            m_prev_walk[p] = wk[p];
        end
    endtask

    task automatic check_all();
        chk("safe_mode", safe_mode, (m_state == S_FAULT) ? 1 : 0);
        chk("fault_code", fault_code, m_code);
        chk("fault_path", fault_path, m_path);
        chk("dwell_a", dwell_a, m_dwell[0]);
        chk("dwell_b", dwell_b, m_dwell[1]);
        chk("walk_remain_a", walk_remain_a, m_walk[0]);
        chk("walk_remain_b", walk_remain_b, m_walk[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic set_lights(input logic [3:0] ca, input logic [1:0] wa, input logic [3:0] cb, input logic [1:0] wb);
        car_a = ca; walk_a = wa; car_b = cb; walk_b = wb;
    endtask

    // Pulse clear_fault with all-red lights, then let IDLE capture them.
    task automatic clear_and_rearm();
        set_lights(C_RED, W_RED, C_RED, W_RED);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        tick();
        chk("rearm_safe_mode", safe_mode, 0);
    endtask

    function automatic logic [3:0] pick_car(input logic [3:0] cur);
        logic [3:0] r;
        if ($urandom_range(0, 3) != 0) return cur;
        case ($urandom_range(0, 9))
            0, 1, 2: r = C_RED;
            3, 4:    r = C_YEL;
            5:       r = C_LEFT;
            6, 7:    r = C_GRN;
            default: r = 4'($urandom_range(0, 15));
        endcase
        return r;
    endfunction

    function automatic logic [1:0] pick_walk(input logic [1:0] cur);
        if ($urandom_range(0, 3) != 0) return cur;
        case ($urandom_range(0, 6))
            0, 1, 2: return W_RED;
            3, 4:    return W_GRN;
            5:       return W_OFF;
            default: return 2'b11;
        endcase
    endfunction

    initial begin
        moves[0] = '{C_GRN,  C_YEL,  1'b0};
        moves[1] = '{C_LEFT, C_YEL,  1'b0};
        moves[2] = '{C_RED,  C_GRN,  1'b0};
        moves[3] = '{C_RED,  C_YEL,  1'b1};
        moves[4] = '{C_YEL,  C_RED,  1'b0};
        moves[5] = '{C_YEL,  C_LEFT, 1'b0};
        moves[6] = '{C_YEL,  C_GRN,  1'b0};

        start = 1'b0;
        isvip = 1'b0; isnight = 1'b0; clear_fault = 1'b0;
        set_lights(C_RED, W_RED, C_RED, W_RED);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_safe_mode", safe_mode, 0);
        chk("reset_fault_code", fault_code, 0);
        chk("reset_dwell_a", dwell_a, 0);
        chk("reset_walk_b", walk_remain_b, 0);
        start = 1'b1;

        // Normal cycle: A green 21, yellow 2, left; B red with walk green throughout.
        set_lights(C_GRN, W_RED, C_RED, W_GRN);
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk("normal_walk_b", walk_remain_b, (k <= WALK_LEN) ? WALK_LEN - k : 0);
        end
        chk("normal_dwell_a_peak", dwell_a, 20);
        car_a = C_YEL; tick(); tick();
        car_a = C_LEFT; tick(); tick();
        chk("normal_no_fault", safe_mode, 0);
        car_a = C_YEL; walk_b = W_RED; tick();
        car_a = C_RED; tick();

        // Conflict: A green with B left.
        set_lights(C_GRN, W_RED, C_LEFT, W_RED);
        tick();
        chk("conflict_safe", safe_mode, 1);
        chk("conflict_code", fault_code, 2);
        chk("conflict_path", fault_path, 0);
        tick();
        chk("conflict_hold", fault_code, 2);
        clear_and_rearm();

        // Gated RED->YELLOW: illegal without override, legal with night mode.
        car_a = C_YEL; tick();
        chk("gated_code", fault_code, 3);
        chk("gated_path", fault_path, 0);
        clear_and_rearm();
        isnight = 1'b1;
        car_a = C_YEL; tick();
        chk("gated_night_ok", safe_mode, 0);
        car_a = C_RED; tick();
        isnight = 1'b0;

        // Illegal codes on both paths in the same cycle: path A wins.
        set_lights(C_RED, 2'b11, 4'b0110, W_RED);
        tick();
        chk("illegal_code", fault_code, 1);
        chk("illegal_path", fault_path, 0);
        clear_and_rearm();

        // Yellow timeout on path B after 8 samples.
        isnight = 1'b1;
        car_b = C_YEL;
        for (int k = 1; k <= YEL_MAX; k++) begin
            tick();
            if (k < YEL_MAX) chk("yel_not_yet", safe_mode, 0);
        end
        chk("yel_code", fault_code, 4);
        chk("yel_path", fault_path, 1);
        isnight = 1'b0;
        set_lights(C_RED, W_RED, C_RED, W_RED);
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        chk("yel_clear_idle", dut.state_reg, S_IDLE);
        chk("yel_clear_safe", safe_mode, 0);
        tick();
        chk("yel_clear_run", dut.state_reg, S_RUN);

        // Asynchronous reset while latched in FAULT.
        car_a = 4'b1111; tick();
        chk("prereset_fault", safe_mode, 1);
        car_a = C_RED;
        #3 start = 1'b0;
        model_reset();
        #1;
        chk("async_safe", safe_mode, 0);
        chk("async_code", fault_code, 0);
        chk("async_path", fault_path, 0);
        chk("async_dwell_b", dwell_b, 0);
        #2 start = 1'b1;
        #1;
        chk("async_idle", dut.state_reg, S_IDLE);

        // Sticky random codes with random overrides and clears.
        for (int n = 0; n < 400; n++) begin
            car_a  = pick_car(car_a);
            car_b  = pick_car(car_b);
            walk_a = pick_walk(walk_a);
            walk_b = pick_walk(walk_b);
            isvip   = ($urandom_range(0, 7) == 0);
            isnight = ($urandom_range(0, 3) == 0);
            clear_fault = ($urandom_range(0, 4) == 0);
            tick();
        end
        clear_fault = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
